// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared reader state encoding, MCU geometry constants and helpers
package jpeg_pkg;

    localparam int MCU_DIM    = 16;
    localparam int MCU_PIXELS = 256;
    localparam int SAMPLE_W   = 9;
    localparam int COORD_W    = 16;
    localparam int MCU_IDX_W  = COORD_W - 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_DRAIN,
        S_RELEASE
    } rd_state_e;

    // Pixel index just past the MCU at position idx, widened so the compare never overflows
    function automatic logic [COORD_W:0] mcu_end(input logic [MCU_IDX_W-1:0] idx);
        return {1'b0, idx, 4'b0000} + (COORD_W+1)'(MCU_DIM);
    endfunction

endpackage

// File: rtl/jpeg_mcu_position.sv
// jpeg_mcu_position: MCU column/row counters, last-MCU detection and global pixel coordinates
module jpeg_mcu_position
    import jpeg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] image_width,
    input  logic [COORD_W-1:0] image_height,
    input  logic [3:0]         pix_x,
    input  logic [3:0]         pix_y,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               last_mcu
);

    logic [MCU_IDX_W-1:0] mcu_x_q, mcu_x_d, mcu_y_q, mcu_y_d;
    logic                 x_wrap, y_last;

    // Wrap detection, coordinate concatenation and counter stepping
    always_comb begin
        x_wrap   = mcu_end(mcu_x_q) >= {1'b0, image_width};
        y_last   = mcu_end(mcu_y_q) >= {1'b0, image_height};
        last_mcu = x_wrap & y_last;
        pixel_x  = {mcu_x_q, pix_x};
        pixel_y  = {mcu_y_q, pix_y};
        mcu_x_d  = clear ? '0 : advance ? (x_wrap ? '0 : mcu_x_q + 1'b1) : mcu_x_q;
        mcu_y_d  = clear ? '0 : (advance & x_wrap) ? mcu_y_q + 1'b1 : mcu_y_q;
    end

    // MCU position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mcu_x_q <= '0;
            mcu_y_q <= '0;
        end else begin
            mcu_x_q <= mcu_x_d;
            mcu_y_q <= mcu_y_d;
        end
    end

endmodule

// File: rtl/jpeg_ycbcr_reader.sv
// jpeg_ycbcr_reader: raster-scans a 16x16 YCbCr MCU buffer into a valid/ready pixel stream.
// Define JPEG_READER_CLIP_EN to suppress pixels that fall outside the frame.
module jpeg_ycbcr_reader
    import jpeg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                Start,
    input  logic [COORD_W-1:0]  ImageWidth,
    input  logic [COORD_W-1:0]  ImageHeight,
    input  logic                McuReady,
    output logic                McuRelease,
    output logic [7:0]          DataOutAddress,
    input  logic [SAMPLE_W-1:0] DataOutY,
    input  logic [SAMPLE_W-1:0] DataOutCb,
    input  logic [SAMPLE_W-1:0] DataOutCr,
    output logic                OutEnable,
    input  logic                OutReady,
    output logic [SAMPLE_W-1:0] OutY,
    output logic [SAMPLE_W-1:0] OutCb,
    output logic [SAMPLE_W-1:0] OutCr,
    output logic [COORD_W-1:0]  OutPixelX,
    output logic [COORD_W-1:0]  OutPixelY,
    output logic                OutFrameEnd
);

    rd_state_e           state_q, state_d;
    logic [7:0]          addr_q, addr_d;
    logic                s1v_q, s1v_d;
    logic                en_q, en_d;
    logic [SAMPLE_W-1:0] y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic [COORD_W-1:0]  px_q, px_d, py_q, py_d;
    logic                fe_q, fe_d;
    logic                rel_q, rel_d;
    logic [COORD_W-1:0]  pixel_x, pixel_y;
    logic                last_mcu, adv, emit, fe_hit;

    jpeg_mcu_position u_pos (
        .clk          (clk),
        .rst          (rst),
        .clear        ((state_q == S_IDLE) & Start),
        .advance      (state_q == S_RELEASE),
        .image_width  (ImageWidth),
        .image_height (ImageHeight),
        .pix_x        (addr_q[3:0]),
        .pix_y        (addr_q[7:4]),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .last_mcu     (last_mcu)
    );

    // Handshake advance, read address lookahead and per-pixel emit/frame-end qualification
    always_comb begin
        adv            = (state_q == S_READ) & s1v_q & (~en_q | OutReady);
        DataOutAddress = (state_q == S_READ) ? (adv ? addr_q + 8'd1 : addr_q) : 8'd0;
`ifdef JPEG_READER_CLIP_EN
        emit   = (pixel_x < ImageWidth) & (pixel_y < ImageHeight);
        fe_hit = last_mcu & (pixel_x == ImageWidth - 16'd1) & (pixel_y == ImageHeight - 16'd1);
`else
        emit   = 1'b1;
        fe_hit = last_mcu & (addr_q == 8'hFF);
`endif
    end

    // Scan FSM: next state, output register loads and release pulse
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        s1v_d   = s1v_q;
        en_d    = en_q;
        y_d     = y_q;
        cb_d    = cb_q;
        cr_d    = cr_q;
        px_d    = px_q;
        py_d    = py_q;
        fe_d    = fe_q;
        rel_d   = 1'b0;
        case (state_q)
            S_IDLE: state_d = Start ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (McuReady) begin
                    state_d = S_READ;
                    addr_d  = 8'd0;
                    s1v_d   = 1'b1;
                end
            end
            S_READ: begin
                if (adv) begin
                    y_d    = DataOutY;
                    cb_d   = DataOutCb;
                    cr_d   = DataOutCr;
                    px_d   = pixel_x;
                    py_d   = pixel_y;
                    en_d   = emit;
                    fe_d   = fe_hit;
                    addr_d = addr_q + 8'd1;
                    if (addr_q == 8'hFF) begin
                        s1v_d   = 1'b0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (~en_q | OutReady) begin
                    en_d    = 1'b0;
                    fe_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rel_d   = 1'b1;
                state_d = last_mcu ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            s1v_q   <= 1'b0;
            en_q    <= 1'b0;
            y_q     <= '0;
            cb_q    <= '0;
            cr_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            fe_q    <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            s1v_q   <= s1v_d;
            en_q    <= en_d;
            y_q     <= y_d;
            cb_q    <= cb_d;
            cr_q    <= cr_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fe_q    <= fe_d;
            rel_q   <= rel_d;
        end
    end

    assign McuRelease  = rel_q;
    assign OutEnable   = en_q;
    assign OutY        = y_q;
    assign OutCb       = cb_q;
    assign OutCr       = cr_q;
    assign OutPixelX   = px_q;
    assign OutPixelY   = py_q;
    assign OutFrameEnd = fe_q;

endmodule

// File: tb/tb_jpeg_ycbcr_reader.sv
// tb_jpeg_ycbcr_reader: directed scoreboard bench for the MCU buffer reader
module tb_jpeg_ycbcr_reader;

    typedef struct packed {
        logic [8:0]  y;
        logic [8:0]  cb;
        logic [8:0]  cr;
        logic [15:0] px;
        logic [15:0] py;
        logic        fe;
    } beat_t;

    logic        clk, rst, Start, McuReady, McuRelease, OutEnable, OutReady, OutFrameEnd;
    logic [15:0] ImageWidth, ImageHeight, OutPixelX, OutPixelY;
    logic [7:0]  DataOutAddress;
    logic [8:0]  DataOutY, DataOutCb, DataOutCr, OutY, OutCb, OutCr;

    logic [8:0]  y_mem [256];
    logic [8:0]  cb_mem[256];
    logic [8:0]  cr_mem[256];

    beat_t       q[$];
    logic [31:0] coords[$];
    int          tests = 0, fails = 0;
    int          beats = 0, rel_cnt = 0, fe_cnt = 0, stalls = 0, cyc = 0;
    int          rel_cyc = 0, beat_cyc = 0;
    logic [8:0]  cb53 = '0, cbff = '0;
    logic        prev_stall = 1'b0, prev_rel = 1'b0;
    logic [63:0] prev_vec = '0;
    logic [7:0]  prev_addr = '0;

    jpeg_ycbcr_reader dut (
        .clk            (clk),
        .rst            (rst),
        .Start          (Start),
        .ImageWidth     (ImageWidth),
        .ImageHeight    (ImageHeight),
        .McuReady       (McuReady),
        .McuRelease     (McuRelease),
        .DataOutAddress (DataOutAddress),
        .DataOutY       (DataOutY),
        .DataOutCb      (DataOutCb),
        .DataOutCr      (DataOutCr),
        .OutEnable      (OutEnable),
        .OutReady       (OutReady),
        .OutY           (OutY),
        .OutCb          (OutCb),
        .OutCr          (OutCr),
        .OutPixelX      (OutPixelX),
        .OutPixelY      (OutPixelY),
        .OutFrameEnd    (OutFrameEnd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffer model: registered read, chroma is the 8x8 4:2:0 subsample of the luma address
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        DataOutY  <= y_mem[DataOutAddress];
        DataOutCb <= cb_mem[DataOutAddress];
        DataOutCr <= cr_mem[DataOutAddress];
    end

    function automatic int cidx(input int a);
        return ((a >> 5) & 7) * 8 + ((a & 15) >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat stream for a whole frame, MCUs in raster order
    task automatic push_frame(input int w, input int h);
        int nx, ny, x, y;
        beat_t b;
        nx = (w + 15) / 16;
        ny = (h + 15) / 16;
        for (int my = 0; my < ny; my++)
            for (int mx = 0; mx < nx; mx++)
                for (int a = 0; a < 256; a++) begin
                    x = mx * 16 + (a % 16);
                    y = my * 16 + (a / 16);
`ifdef JPEG_READER_CLIP_EN
                    if (x >= w || y >= h) continue;
                    b.fe = (x == w - 1) && (y == h - 1);
`else
                    b.fe = (mx == nx - 1) && (my == ny - 1) && (a == 255);
`endif
                    b.y  = y_mem[a];
                    b.cb = cb_mem[a];
                    b.cr = cr_mem[a];
                    b.px = 16'(x);
                    b.py = 16'(y);
                    q.push_back(b);
                end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
    endtask

    task automatic run(input int target, input bit rnd);
        for (int i = 0; i < 20000 && rel_cnt < target; i++) begin
            @(posedge clk); #1;
            if (i == 3) McuReady = 1'b0;
            if (rnd) OutReady = 1'($urandom_range(0, 1));
        end
        chk("release_timeout", 64'(rel_cnt >= target), 64'd1);
        OutReady = 1'b1;
    endtask

    // Output monitor: scoreboard pops, stall stability, release pulse tracking
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_rel   = 1'b0;
        end else begin
            if (McuRelease) begin
                chk("release_pulse_width", 64'(prev_rel), 64'd0);
                rel_cnt++;
                rel_cyc = cyc;
            end
            prev_rel = McuRelease;
            if (prev_stall) begin
                chk("stall_hold", {3'b0, OutEnable, OutY, OutCb, OutCr, OutPixelX, OutPixelY, OutFrameEnd}, prev_vec);
                if (OutEnable && !OutReady) chk("stall_addr", 64'(DataOutAddress), 64'(prev_addr));
            end
            if (OutEnable && OutReady) begin
                beats++;
                beat_cyc = cyc;
                if (OutFrameEnd) fe_cnt++;
                coords.push_back({OutPixelX, OutPixelY});
                if (OutPixelX == 16'd5 && OutPixelY == 16'd3) cb53 = OutCb;
                if (OutPixelX == 16'd15 && OutPixelY == 16'd15) cbff = OutCb;
                chk("beat_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_y", 64'(OutY), 64'(e.y));
                    chk("beat_cb", 64'(OutCb), 64'(e.cb));
                    chk("beat_cr", 64'(OutCr), 64'(e.cr));
                    chk("beat_xy", {32'b0, OutPixelX, OutPixelY}, {32'b0, e.px, e.py});
                    chk("beat_frame_end", 64'(OutFrameEnd), 64'(e.fe));
                end
            end
            if (OutEnable && !OutReady) stalls++;
            prev_stall = OutEnable && !OutReady;
            prev_vec   = {3'b0, OutEnable, OutY, OutCb, OutCr, OutPixelX, OutPixelY, OutFrameEnd};
            prev_addr  = DataOutAddress;
        end
    end

    initial begin
        int base, r0, f0, s0;
        rst = 1'b1; Start = 1'b0; McuReady = 1'b0; OutReady = 1'b1;
        ImageWidth = 16'd16; ImageHeight = 16'd16;
        for (int a = 0; a < 256; a++) begin
            y_mem[a]  = 9'(a);
            cb_mem[a] = 9'(cidx(a));
            cr_mem[a] = 9'(cidx(a) * 3 + 100);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_enable", 64'(OutEnable), 64'd0);
        chk("reset_release", 64'(McuRelease), 64'd0);
        chk("reset_frame_end", 64'(OutFrameEnd), 64'd0);
        chk("reset_data", {19'b0, OutY, OutCb, OutCr}, 64'd0);
        chk("reset_xy", {32'b0, OutPixelX, OutPixelY}, 64'd0);
        chk("reset_addr", 64'(DataOutAddress), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 16x16 frame, ready always high, latency and chroma spot checks
        push_frame(16, 16);
        base = beats; r0 = rel_cnt; f0 = fe_cnt;
        pulse_start();
        repeat (5) @(posedge clk);
        #1 McuReady = 1'b1;
        @(negedge clk) chk("wait_addr", 64'(DataOutAddress), 64'd0);
        @(posedge clk); @(negedge clk) chk("latency_t1", 64'(OutEnable), 64'd0);
        @(posedge clk); @(negedge clk) chk("latency_t2", 64'(OutEnable), 64'd1);
        run(r0 + 1, 1'b0);
        chk("t1_beats", 64'(beats - base), 64'd256);
        chk("t1_queue_empty", 64'(q.size()), 64'd0);
        chk("t1_releases", 64'(rel_cnt - r0), 64'd1);
        chk("t1_frame_ends", 64'(fe_cnt - f0), 64'd1);
        chk("t1_release_latency", 64'(rel_cyc - beat_cyc), 64'd2);
        chk("chroma_5_3", 64'(cb53), 64'd10);
        chk("chroma_15_15", 64'(cbff), 64'd63);
        base = beats;
        #1 McuReady = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("idle_ignores_ready", 64'(beats - base), 64'd0);
        chk("idle_enable", 64'(OutEnable), 64'd0);
        #1 McuReady = 1'b0;

        // Same frame under random backpressure
        push_frame(16, 16);
        base = beats; r0 = rel_cnt; s0 = stalls;
        pulse_start();
        #1 McuReady = 1'b1;
        run(r0 + 1, 1'b1);
        chk("t2_beats", 64'(beats - base), 64'd256);
        chk("t2_queue_empty", 64'(q.size()), 64'd0);
        chk("t2_stalls_seen", 64'(stalls > s0), 64'd1);

        // 32x32 frame, four MCUs
        ImageWidth = 16'd32; ImageHeight = 16'd32;
        push_frame(32, 32);
        base = beats; r0 = rel_cnt; f0 = fe_cnt;
        pulse_start();
        for (int m = 0; m < 4; m++) begin
            #1 McuReady = 1'b1;
            run(r0 + m + 1, 1'b0);
        end
        chk("t3_beats", 64'(beats - base), 64'd1024);
        chk("t3_releases", 64'(rel_cnt - r0), 64'd4);
        chk("t3_frame_ends", 64'(fe_cnt - f0), 64'd1);
        chk("t3_mcu1_start", 64'(coords[base + 256]), {32'b0, 16'd16, 16'd0});
        chk("t3_mcu2_start", 64'(coords[base + 512]), {32'b0, 16'd0, 16'd16});
        chk("t3_queue_empty", 64'(q.size()), 64'd0);

        // 24x16 frame, partial second MCU
        ImageWidth = 16'd24; ImageHeight = 16'd16;
        push_frame(24, 16);
        base = beats; r0 = rel_cnt; f0 = fe_cnt;
        pulse_start();
        for (int m = 0; m < 2; m++) begin
            #1 McuReady = 1'b1;
            run(r0 + m + 1, 1'b0);
        end
`ifdef JPEG_READER_CLIP_EN
        chk("t4_beats", 64'(beats - base), 64'd384);
        chk("t4_last_xy", 64'(coords[beats - 1]), {32'b0, 16'd23, 16'd15});
`else
        chk("t4_beats", 64'(beats - base), 64'd512);
        chk("t4_last_xy", 64'(coords[beats - 1]), {32'b0, 16'd31, 16'd15});
`endif
        chk("t4_frame_ends", 64'(fe_cnt - f0), 64'd1);
        chk("t4_queue_empty", 64'(q.size()), 64'd0);

        // Reset mid-MCU, then a clean restart
        ImageWidth = 16'd16; ImageHeight = 16'd16;
        push_frame(16, 16);
        base = beats; r0 = rel_cnt;
        pulse_start();
        #1 McuReady = 1'b1;
        for (int i = 0; i < 2000 && beats < base + 100; i++) @(posedge clk);
        chk("t6_reach_beat_100", 64'(beats >= base + 100), 64'd1);
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t6_enable_after_rst", 64'(OutEnable), 64'd0);
        chk("t6_addr_after_rst", 64'(DataOutAddress), 64'd0);
        chk("t6_release_after_rst", 64'(McuRelease), 64'd0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        base = beats;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t6_idle_after_rst", 64'(beats - base), 64'd0);
        chk("t6_no_release", 64'(rel_cnt - r0), 64'd0);
        push_frame(16, 16);
        pulse_start();
        run(r0 + 1, 1'b0);
        chk("t6_restart_beats", 64'(beats - base), 64'd256);
        chk("t6_restart_first_xy", 64'(coords[base]), 64'd0);
        chk("t6_queue_empty", 64'(q.size()), 64'd0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
